// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-of-day keeper with a RUN / SET_HOUR / SET_MIN setting
// controller driven by two debounced buttons (MODE and ADJ).
//
// Each button arrives as a 2-bit press-state code from an upstream debounce
// stage running on i_clk: 00 idle, 11 pressed, 10 short release, 01 long
// release. The code is registered once, then compared with its previous value
// to form one short or long event per press. An event changes state or a field
// on the edge after the code was registered.
//
// Optional feature, enabled by defining CLKSET_AUTOREPEAT_EN:
//   While in a SET state with ADJ held at 11, the selected field steps +1 after
//   DIV_CONST cycles and then every DIV_CONST/4 cycles. The long release that
//   ends such a hold is swallowed when at least one repeat step was applied.
// When the macro is undefined, holding ADJ does nothing until it is released.

module clock_set_ctrl #(
  parameter int unsigned DIV_CONST = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_mode_state,
  input  logic [1:0] i_adj_state,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [1:0] o_mode,
  output logic       o_blink
);

  // Debounce press-state codes.
  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_LONG  = 2'b01;
  localparam logic [1:0] CODE_SHORT = 2'b10;
  localparam logic [1:0] CODE_PRESS = 2'b11;

  // Prescaler limits. DIV_CONST is at least 8, so both fractions are nonzero.
  localparam logic [27:0] PRESC_MAX  = 28'(DIV_CONST - 1);
  localparam logic [27:0] BLINK_HALF = 28'(DIV_CONST / 2);

  // The encoding doubles as the o_mode output value.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  // ---------------------------------------------------------------------
  // Field step helpers: +1 or -1 with wrap-around.
  // ---------------------------------------------------------------------
  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [1:0]  mode_cur_q, mode_prev_q;
  logic [1:0]  adj_cur_q,  adj_prev_q;
  state_e      state_q,    state_d;
  logic [27:0] presc_q,    presc_d;
  logic [4:0]  hours_q,    hours_d;
  logic [5:0]  min_q,      min_d;
  logic [5:0]  sec_q,      sec_d;
  logic        blink_q,    blink_d;

  // Decoded events and derived strobes.
  logic mode_short, mode_long, mode_evt;
  logic adj_short, adj_long;
  logic adj_inc, adj_dec;
  logic state_chg;
  logic sec_tick;

  // Register each button code and keep the previous registered code.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_cur_q  <= CODE_IDLE;
      mode_prev_q <= CODE_IDLE;
      adj_cur_q   <= CODE_IDLE;
      adj_prev_q  <= CODE_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values;
      // with = the prev register would capture the freshly written current code.
      mode_cur_q  <= i_mode_state;
      mode_prev_q <= mode_cur_q;
      adj_cur_q   <= i_adj_state;
      adj_prev_q  <= adj_cur_q;
    end
  end

  // An event fires only on entry into a release code, so a held code is one event.
  assign mode_short = (mode_cur_q == CODE_SHORT) && (mode_prev_q != CODE_SHORT);
  assign mode_long  = (mode_cur_q == CODE_LONG)  && (mode_prev_q != CODE_LONG);
  assign adj_short  = (adj_cur_q  == CODE_SHORT) && (adj_prev_q  != CODE_SHORT);
  assign adj_long   = (adj_cur_q  == CODE_LONG)  && (adj_prev_q  != CODE_LONG);
  assign mode_evt   = mode_short | mode_long;

  // Next-state logic for the setting state machine.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mode_long) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (mode_long)       state_d = ST_RUN;
        else if (mode_short) state_d = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (mode_long)       state_d = ST_RUN;
        else if (mode_short) state_d = ST_SET_HOUR;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // A second boundary only counts while running; a transition in the same
  // cycle takes precedence further down.
  assign sec_tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

`ifdef CLKSET_AUTOREPEAT_EN
  // ---------------------------------------------------------------------
  // Auto-repeat while ADJ is held in a SET state.
  // ---------------------------------------------------------------------
  localparam logic [27:0] REPEAT_RELOAD = 28'(DIV_CONST - DIV_CONST / 4);

  logic [27:0] hold_q, hold_d;
  logic        rep_seen_q, rep_seen_d;
  logic        rep_step;

  // Count consecutive held cycles; the first step lands on cycle DIV_CONST and
  // the reload makes later steps DIV_CONST/4 cycles apart.
  always_comb begin
    hold_d     = '0;
    rep_step   = 1'b0;
    rep_seen_d = rep_seen_q;
    if ((adj_cur_q == CODE_PRESS) && (adj_prev_q != CODE_PRESS)) rep_seen_d = 1'b0;
    if (state_chg) rep_seen_d = 1'b0;
    if ((state_q != ST_RUN) && (adj_cur_q == CODE_PRESS) && !state_chg) begin
      if (hold_q == PRESC_MAX) begin
        rep_step = 1'b1;
        hold_d   = REPEAT_RELOAD;
      end else begin
        hold_d = hold_q + 28'd1;
      end
    end
    // A step lost to a simultaneous MODE event does not swallow the release.
    if (rep_step && !mode_evt) rep_seen_d = 1'b1;
  end

  // Hold counter and the "a repeat step happened" flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q     <= '0;
      rep_seen_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      rep_seen_q <= rep_seen_d;
    end
  end

  assign adj_inc = adj_short | rep_step;
  assign adj_dec = adj_long & ~rep_seen_q;
`else
  assign adj_inc = adj_short;
  assign adj_dec = adj_long;
`endif

  // Prescaler, timekeeping, field adjust and blink request.
  always_comb begin
    presc_d = presc_q + 28'd1;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;

    // Any state entry restarts the prescaler so the first second is full length.
    if (state_chg || (presc_q == PRESC_MAX)) presc_d = '0;

    if (state_chg) begin
      if (state_d == ST_RUN) sec_d = '0;
    end else if (state_q == ST_RUN) begin
      if (sec_tick) begin
        sec_d = sixty_step(sec_q, 1'b1);
        if (sec_q == 6'd59) begin
          min_d = sixty_step(min_q, 1'b1);
          if (min_q == 6'd59) hours_d = hour_step(hours_q, 1'b1);
        end
      end
    end else if (!mode_evt && (adj_inc || adj_dec)) begin
      // Only one of inc/dec can be active: they need different ADJ codes.
      if (state_q == ST_SET_HOUR) hours_d = hour_step(hours_q, adj_inc);
      else                        min_d   = sixty_step(min_q, adj_inc);
    end

    // Computed from next-state values so the registered blink lines up with
    // the registered prescaler.
    blink_d = (state_d != ST_RUN) && (presc_d >= BLINK_HALF);
  end

  // State, prescaler and time registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      hours_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
    end
  end

  assign o_hours   = hours_q;
  assign o_minutes = min_q;
  assign o_seconds = sec_q;
  assign o_mode    = state_q;
  assign o_blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with DIV_CONST = 20.
// Inputs are driven and outputs sampled on the falling edge of i_clk.
module tb_clock_set_ctrl;

  localparam int DIV = 20;
  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_LONG  = 2'b01;
  localparam logic [1:0] C_SHORT = 2'b10;
  localparam logic [1:0] C_PRESS = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_st;
  logic [1:0] adj_st;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  always #5 clk = ~clk;

  clock_set_ctrl #(.DIV_CONST(DIV)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mode_state (mode_st),
    .i_adj_state  (adj_st),
    .o_hours      (hours),
    .o_minutes    (minutes),
    .o_seconds    (seconds),
    .o_mode       (mode),
    .o_blink      (blink)
  );

  typedef struct {
    string tag;
    int    h;
    int    m;
    int    s;
    int    md;
    int    bl;   // -1: blink not checked at this point
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input int h, input int m, input int s,
                          input int md, input int bl);
    exp_t e;
    e.tag = tag; e.h = h; e.m = m; e.s = s; e.md = md; e.bl = bl;
    sb_q.push_back(e);
  endtask

  // Expected time given as total seconds since midnight.
  task automatic push_time(input string tag, input int secs, input int md, input int bl);
    int t;
    t = secs % 86400;
    push_exp(tag, t / 3600, (t / 60) % 60, t % 60, md, bl);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      cmp({e.tag, ".hours"},   32'(hours),   e.h);
      cmp({e.tag, ".minutes"}, 32'(minutes), e.m);
      cmp({e.tag, ".seconds"}, 32'(seconds), e.s);
      cmp({e.tag, ".mode"},    32'(mode),    e.md);
      if (e.bl >= 0) cmp({e.tag, ".blink"}, 32'(blink), e.bl);
    end
  endtask

  task automatic expect_hms(input string tag, input int h, input int m, input int s,
                            input int md, input int bl);
    push_exp(tag, h, m, s, md, bl);
    pop_check();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press then release with the given codes; C_IDLE leaves that button alone.
  // Returns on the falling edge right after the resulting update.
  task automatic press(input logic [1:0] mcode, input logic [1:0] acode);
    if (mcode != C_IDLE) mode_st = C_PRESS;
    if (acode != C_IDLE) adj_st  = C_PRESS;
    tick(1);
    if (mcode != C_IDLE) mode_st = mcode;
    if (acode != C_IDLE) adj_st  = acode;
    tick(2);
  endtask

  task automatic release_all();
    mode_st = C_IDLE;
    adj_st  = C_IDLE;
    tick(1);
  endtask

  // Safety net so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    mode_st = C_IDLE;
    adj_st  = C_IDLE;
    tick(2);
    expect_hms("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Free run for one minute: one second every DIV cycles, blink stays low.
    for (int k = 1; k <= 60 * DIV; k++) begin
      tick(1);
      push_time("run1", k / DIV, 0, 0);
      pop_check();
    end
    tick(2 * DIV);
    expect_hms("run1_end", 0, 1, 2, 0, 0);

    // Enter SET_HOUR; time is frozen and blink follows the prescaler.
    press(C_LONG, C_IDLE);
    expect_hms("enter_set_hour", 0, 1, 2, 1, 0);
    release_all();
    tick(8);
    expect_hms("blink_low_9", 0, 1, 2, 1, 0);
    tick(1);
    expect_hms("blink_high_10", 0, 1, 2, 1, 1);
    tick(9);
    expect_hms("blink_high_19", 0, 1, 2, 1, 1);
    tick(1);
    expect_hms("blink_low_20", 0, 1, 2, 1, 0);
    tick(DIV);
    expect_hms("frozen", 0, 1, 2, 1, 0);

    // Hour adjust with wrap in both directions.
    for (int i = 1; i <= 3; i++) begin
      press(C_IDLE, C_SHORT);
      expect_hms("hour_inc", i, 1, 2, 1, -1);
      release_all();
    end
    for (int i = 2; i >= -1; i--) begin
      press(C_IDLE, C_LONG);
      expect_hms("hour_dec", (i < 0) ? 23 : i, 1, 2, 1, -1);
      release_all();
    end
    press(C_IDLE, C_SHORT);
    expect_hms("hour_wrap_up", 0, 1, 2, 1, -1);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("hour_wrap_down", 23, 1, 2, 1, -1);
    release_all();

    // A short-release code held for many cycles is still one event.
    adj_st = C_PRESS;
    tick(1);
    adj_st = C_SHORT;
    tick(100);
    expect_hms("held_short", 0, 1, 2, 1, -1);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("hour_back", 23, 1, 2, 1, -1);
    release_all();

    // SET_MIN and minute adjust with wrap.
    press(C_SHORT, C_IDLE);
    expect_hms("enter_set_min", 23, 1, 2, 2, 0);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("min_dec", 23, 0, 2, 2, -1);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("min_wrap_down", 23, 59, 2, 2, -1);
    release_all();
    press(C_IDLE, C_SHORT);
    expect_hms("min_wrap_up", 23, 0, 2, 2, -1);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("min_back", 23, 59, 2, 2, -1);
    release_all();

    // MODE long and ADJ short together: back to RUN, ADJ discarded, seconds cleared.
    press(C_LONG, C_SHORT);
    expect_hms("mode_wins", 23, 59, 0, 0, 0);
    release_all();

    // Full minute from 23:59:00, crossing midnight; first tick DIV cycles after entry.
    for (int j = 1; j <= 60 * DIV - 1; j++) begin
      tick(1);
      push_time("run2", 23 * 3600 + 59 * 60 + (1 + j) / DIV, 0, 0);
      pop_check();
    end

    // ADJ and MODE short have no effect in RUN.
    press(C_IDLE, C_SHORT);
    expect_hms("run_adj_short", 0, 0, 0, 0, 0);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("run_adj_long", 0, 0, 0, 0, 0);
    release_all();
    press(C_SHORT, C_IDLE);
    expect_hms("run_mode_short", 0, 0, 0, 0, 0);
    release_all();

    // Reset in the middle of SET_HOUR clears outputs without a clock edge.
    press(C_LONG, C_IDLE);
    expect_hms("set_hour_again", 0, 0, 0, 1, -1);
    release_all();
    for (int i = 0; i < 7; i++) begin
      press(C_IDLE, C_SHORT);
      release_all();
    end
    expect_hms("hours_seven", 7, 0, 0, 1, -1);
    rst = 1'b1;
    #1;
    expect_hms("async_reset", 0, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    expect_hms("after_reset", 0, 0, 0, 0, 0);

    // Prepare minutes = 58 in SET_MIN.
    press(C_LONG, C_IDLE);
    expect_hms("post_rst_set_hour", 0, 0, 0, 1, -1);
    release_all();
    press(C_SHORT, C_IDLE);
    expect_hms("post_rst_set_min", 0, 0, 0, 2, -1);
    release_all();
    press(C_IDLE, C_LONG);
    release_all();
    press(C_IDLE, C_LONG);
    expect_hms("min_58", 0, 58, 0, 2, -1);
    release_all();

    // Hold ADJ pressed for 36 cycles, then long release.
    adj_st = C_PRESS;
`ifdef CLKSET_AUTOREPEAT_EN
    tick(20);
    expect_hms("rep_before", 0, 58, 0, 2, -1);
    tick(1);
    expect_hms("rep_step1", 0, 59, 0, 2, -1);
    tick(5);
    expect_hms("rep_step2", 0, 0, 0, 2, -1);
    tick(5);
    expect_hms("rep_step3", 0, 1, 0, 2, -1);
    tick(5);
    expect_hms("rep_step4", 0, 2, 0, 2, -1);
    adj_st = C_LONG;
    tick(2);
    expect_hms("rep_release", 0, 2, 0, 2, -1);
`else
    tick(36);
    expect_hms("hold_no_effect", 0, 58, 0, 2, -1);
    adj_st = C_LONG;
    tick(2);
    expect_hms("hold_release", 0, 57, 0, 2, -1);
`endif
    release_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
